// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, functs, ALU codes,
// FSM state encodings and the registered control bundle.
package multi_cycle_ctrl_pkg;

    localparam int STATE_W_DEF = 5;

    // Opcodes (Inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type functs (Inst[5:0])
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // ALU_operation codes understood by data_path
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    typedef enum logic [4:0] {
        S_IF  = 5'd0,
        S_ID  = 5'd1,
        S_MA  = 5'd2,
        S_MRD = 5'd3,
        S_MWR = 5'd4,
        S_WBL = 5'd5,
        S_EXR = 5'd6,
        S_WBR = 5'd7,
        S_JR  = 5'd8,
        S_EXI = 5'd9,
        S_WBI = 5'd10,
        S_LUI = 5'd11,
        S_BR  = 5'd12,
        S_J   = 5'd13
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       data2mem;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    // Instruction-independent controls of a state; jal and writeback suppression
    // are the only instruction facts that reach the registered bundle.
    function automatic ctrl_t ctrl_for(input state_t s, input logic is_jal, input logic wb_sup);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.iord      = 1'b1;
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_ID: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b11;
            end
            S_MA:  c.alu_src_b = 2'b10;
            S_MRD: begin
                c.alu_src_b = 2'b10;
                c.mem_read  = 1'b1;
            end
            S_MWR: begin
                c.alu_src_b = 2'b10;
                c.mem_write = 1'b1;
            end
            S_WBL: begin
                c.mem_to_reg = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_WBR: begin
                c.reg_dst   = 2'b01;
                c.reg_write = ~wb_sup;
            end
            S_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
            end
            S_EXI: c.alu_src_b = 2'b10;
            S_WBI: c.reg_write = ~wb_sup;
            S_LUI: begin
                c.mem_to_reg = 2'b10;
                c.reg_write  = 1'b1;
            end
            S_BR: begin
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_J: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                if (is_jal) begin
                    c.reg_dst    = 2'b10;
                    c.mem_to_reg = 2'b11;
                    c.reg_write  = 1'b1;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_op_dec.sv
// Combinational instruction decode: ALU op, sign-extension, legality and
// whether the op can raise an arithmetic overflow.
import multi_cycle_ctrl_pkg::*;

module alu_op_dec (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       signext,
    output logic       legal,
    output logic       ovf_chk
);

    always_comb begin
        alu_op  = ALU_ADD;
        signext = 1'b0;
        legal   = 1'b1;
        ovf_chk = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:  ovf_chk = 1'b1;
                    F_ADDU: alu_op  = ALU_ADD;
                    F_SUB: begin
                        alu_op  = ALU_SUB;
                        ovf_chk = 1'b1;
                    end
                    F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_SLL:  alu_op = ALU_SLL;
                    F_SRL:  alu_op = ALU_SRL;
                    F_SRA:  alu_op = ALU_SRA;
                    F_JR:   alu_op = ALU_ADD;   // rs + $0 lands in ALU_Out
                    default: legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW: signext = 1'b1;
            OP_ADDI: begin
                signext = 1'b1;
                ovf_chk = 1'b1;
            end
            OP_SLTI: begin
                alu_op  = ALU_SLT;
                signext = 1'b1;
            end
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            OP_XORI: alu_op = ALU_XOR;
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            OP_LUI, OP_J, OP_JAL: alu_op = ALU_ADD;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore FSM sequencing the multi-cycle MIPS data_path. Define MCCTRL_OVF_SUPPRESS_EN
// to block the register writeback of add/sub/addi that overflowed in execute.
import multi_cycle_ctrl_pkg::*;

module multi_cycle_ctrl #(
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Inst_in,
    input  logic               zero,
    input  logic               overflow,
    input  logic               MIO_ready,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               Beq,
    output logic               Signext,
    output logic               data2Mem,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [3:0]         ALU_operation,
    output logic               illegal_inst,
    output logic [STATE_W-1:0] state_out
);

    state_t     state, nxt;
    ctrl_t      ctrl;
    logic [5:0] opcode, funct;
    logic [3:0] dec_alu;
    logic       dec_sx, dec_legal, dec_ovf, wb_sup;

    assign opcode = Inst_in[31:26];
    assign funct  = Inst_in[5:0];

    alu_op_dec u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .alu_op  (dec_alu),
        .signext (dec_sx),
        .legal   (dec_legal),
        .ovf_chk (dec_ovf)
    );

`ifdef MCCTRL_OVF_SUPPRESS_EN
    assign wb_sup = (state == S_EXR || state == S_EXI) && dec_ovf && overflow;
    logic unused_bits;
    assign unused_bits = ^{zero, Inst_in[25:6]};
`else
    assign wb_sup = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{zero, overflow, dec_ovf, Inst_in[25:6]};
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IF:  if (MIO_ready) nxt = S_ID;
            S_ID: begin
                case (opcode)
                    OP_RTYPE:                              nxt = S_EXR;
                    OP_LW, OP_SW:                          nxt = S_MA;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EXI;
                    OP_LUI:                                nxt = S_LUI;
                    OP_BEQ, OP_BNE:                        nxt = S_BR;
                    OP_J, OP_JAL:                          nxt = S_J;
                    default:                               nxt = S_IF;
                endcase
                if (!dec_legal) nxt = S_IF;
            end
            S_MA:  nxt = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD: if (MIO_ready) nxt = S_WBL;
            S_MWR: if (MIO_ready) nxt = S_IF;
            S_EXR: nxt = (funct == F_JR) ? S_JR : S_WBR;
            S_EXI: nxt = S_WBI;
            default: nxt = S_IF;
        endcase
    end

    // Control bundle is registered from the next state, so it changes with state
    // and async reset forces S_IF values in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IF;
            ctrl  <= ctrl_for(S_IF, 1'b0, 1'b0);
        end else begin
            state <= nxt;
            ctrl  <= ctrl_for(nxt, opcode == OP_JAL, wb_sup);
        end
    end

    // Instruction-dependent outputs follow Inst_R, which is only valid after S_IF.
    always_comb begin
        ALU_operation = ALU_ADD;
        Signext       = 1'b0;
        case (state)
            S_EXR:               ALU_operation = dec_alu;
            S_EXI: begin
                ALU_operation = dec_alu;
                Signext       = dec_sx;
            end
            S_WBI:               Signext = dec_sx;
            S_BR:                ALU_operation = ALU_SUB;
            S_MA, S_MRD, S_MWR:  Signext = 1'b1;
            default: ;
        endcase
    end

    assign Beq          = (state == S_BR) && (opcode == OP_BEQ);
    assign illegal_inst = (state == S_ID) && !dec_legal;

    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IorD        = ctrl.iord;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign data2Mem    = ctrl.data2mem;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign state_out   = STATE_W'(state);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes per-cycle expected state and
// control vectors, a negedge monitor pops and compares them.
import multi_cycle_ctrl_pkg::*;

module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst_in;
    logic        zero, overflow, MIO_ready;
    logic        MemRead, MemWrite, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond;
    logic        Beq, Signext, data2Mem, illegal_inst;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0]  ALU_operation;
    logic [4:0]  state_out;

    int checks = 0;
    int errors = 0;

    logic [4:0]  q_st[$];
    logic [24:0] q_cv[$];
    string       q_nm[$];

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.STATE_W(5)) dut (
        .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
        .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .Beq(Beq), .Signext(Signext), .data2Mem(data2Mem), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALU_operation(ALU_operation), .illegal_inst(illegal_inst), .state_out(state_out)
    );

    function automatic logic [24:0] mk(
        input logic mr, mw, iord, irw, rw, pcw, pcwc, beq, sx, d2m,
        input logic [1:0] rd, m2r, sa, sb, ps, input logic [3:0] alu, input logic ill);
        return {ill, mr, mw, iord, irw, rw, pcw, pcwc, beq, sx, d2m, rd, m2r, sa, sb, ps, alu};
    endfunction

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (q_st.size() > 0) begin
            logic [4:0]  est;
            logic [24:0] ecv, acv;
            string       nm;
            est = q_st.pop_front();
            ecv = q_cv.pop_front();
            nm  = q_nm.pop_front();
            acv = {illegal_inst, MemRead, MemWrite, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond,
                   Beq, Signext, data2Mem, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_operation};
            checks++;
            if (state_out !== est || acv !== ecv) begin
                errors++;
                $display("FAIL %s: state got %0d want %0d, ctrl got %h want %h",
                         nm, state_out, est, acv, ecv);
            end
        end
    end

    task automatic step(input string nm, input logic [4:0] st, input logic [24:0] cv,
                        input logic rdy, input logic ovf);
        MIO_ready = rdy;
        overflow  = ovf;
        q_st.push_back(st);
        q_cv.push_back(cv);
        q_nm.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    logic [24:0] IFV, IDV, EXIV, MAV, MRDV, MWRV, WBLV, EXRV, WBRV, BRV, JALV, JRV, LUIV;
    logic        wbr_ovf_rw;

    initial begin
        IFV  = mk(1,0,1,1,0,1,0,0,0,0, 2'b00,2'b00,2'b01,2'b01,2'b00, ALU_ADD, 0);
        IDV  = mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b11,2'b00, ALU_ADD, 0);
        MAV  = mk(0,0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b10,2'b00, ALU_ADD, 0);
        MRDV = mk(1,0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b10,2'b00, ALU_ADD, 0);
        MWRV = mk(0,1,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b10,2'b00, ALU_ADD, 0);
        WBLV = mk(0,0,0,0,1,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,2'b00, ALU_ADD, 0);
        BRV  = mk(0,0,0,0,0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, ALU_SUB, 0);
        JALV = mk(0,0,0,0,1,1,0,0,0,0, 2'b10,2'b11,2'b00,2'b00,2'b10, ALU_ADD, 0);
        JRV  = mk(0,0,0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11, ALU_ADD, 0);
        LUIV = mk(0,0,0,0,1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,2'b00, ALU_ADD, 0);
        EXRV = mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, ALU_ADD, 0);
        WBRV = mk(0,0,0,0,1,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00, ALU_ADD, 0);
`ifdef MCCTRL_OVF_SUPPRESS_EN
        wbr_ovf_rw = 1'b0;
`else
        wbr_ovf_rw = 1'b1;
`endif

        reset = 1'b1; Inst_in = 32'h0; zero = 1'b0; overflow = 1'b0; MIO_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", S_IF, IFV, 1'b1, 1'b0);
        reset = 1'b0;

        // addi: IF stall once, then IF, ID, EXI, WBI
        Inst_in = 32'h20080005;
        step("addi_if_stall", S_IF, IFV, 1'b0, 1'b0);
        step("addi_if", S_IF, IFV, 1'b1, 1'b0);
        step("addi_id", S_ID, IDV, 1'b1, 1'b0);
        EXIV = mk(0,0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b10,2'b00, ALU_ADD, 0);
        step("addi_exi", S_EXI, EXIV, 1'b1, 1'b0);
        step("addi_wbi", S_WBI, mk(0,0,0,0,1,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,2'b00, ALU_ADD, 0), 1'b1, 1'b0);

        // lw with memory wait in S_MRD
        Inst_in = 32'h8C090004;
        step("lw_if", S_IF, IFV, 1'b1, 1'b0);
        step("lw_id", S_ID, IDV, 1'b1, 1'b0);
        step("lw_ma", S_MA, MAV, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("lw_mrd_wait", S_MRD, MRDV, 1'b0, 1'b0);
        step("lw_mrd_done", S_MRD, MRDV, 1'b1, 1'b0);
        step("lw_wbl", S_WBL, WBLV, 1'b1, 1'b0);

        // beq / bne
        Inst_in = 32'h1000FFFF;
        step("beq_if", S_IF, IFV, 1'b1, 1'b0);
        step("beq_id", S_ID, IDV, 1'b1, 1'b0);
        step("beq_br", S_BR, BRV, 1'b1, 1'b0);
        Inst_in = 32'h1400FFFF;
        step("bne_if", S_IF, IFV, 1'b1, 1'b0);
        step("bne_id", S_ID, IDV, 1'b1, 1'b0);
        step("bne_br", S_BR, mk(0,0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, ALU_SUB, 0), 1'b1, 1'b0);

        // jal, jr
        Inst_in = 32'h0C000010;
        step("jal_if", S_IF, IFV, 1'b1, 1'b0);
        step("jal_id", S_ID, IDV, 1'b1, 1'b0);
        step("jal_j", S_J, JALV, 1'b1, 1'b0);
        Inst_in = 32'h03E00008;
        step("jr_if", S_IF, IFV, 1'b1, 1'b0);
        step("jr_id", S_ID, IDV, 1'b1, 1'b0);
        step("jr_exr", S_EXR, EXRV, 1'b1, 1'b0);
        step("jr_jr", S_JR, JRV, 1'b1, 1'b0);

        // illegal opcode and illegal funct: one-cycle pulse in S_ID
        Inst_in = 32'h7C000000;
        step("ill_op_if", S_IF, IFV, 1'b1, 1'b0);
        step("ill_op_id", S_ID, mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b11,2'b00, ALU_ADD, 1), 1'b1, 1'b0);
        step("ill_op_back", S_IF, IFV, 1'b0, 1'b0);
        Inst_in = 32'h0000003F;
        step("ill_fn_if", S_IF, IFV, 1'b1, 1'b0);
        step("ill_fn_id", S_ID, mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b11,2'b00, ALU_ADD, 1), 1'b1, 1'b0);

        // sw, reset asserted while S_MWR is waiting
        Inst_in = 32'hAC090004;
        step("sw_if", S_IF, IFV, 1'b1, 1'b0);
        step("sw_id", S_ID, IDV, 1'b1, 1'b0);
        step("sw_ma", S_MA, MAV, 1'b1, 1'b0);
        step("sw_mwr", S_MWR, MWRV, 1'b0, 1'b0);
        reset = 1'b1;
        step("sw_reset_mwr", S_IF, IFV, 1'b0, 1'b0);
        reset = 1'b0;

        // R-type sub (no overflow) and add with overflow in S_EXR
        Inst_in = 32'h01285022;
        step("sub_if", S_IF, IFV, 1'b1, 1'b0);
        step("sub_id", S_ID, IDV, 1'b1, 1'b0);
        step("sub_exr", S_EXR, mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, ALU_SUB, 0), 1'b1, 1'b0);
        step("sub_wbr", S_WBR, WBRV, 1'b1, 1'b0);
        Inst_in = 32'h01285020;
        step("add_if", S_IF, IFV, 1'b1, 1'b0);
        step("add_id", S_ID, IDV, 1'b1, 1'b0);
        step("add_exr_ovf", S_EXR, EXRV, 1'b1, 1'b1);
        step("add_wbr_ovf", S_WBR, mk(0,0,0,0,wbr_ovf_rw,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00, ALU_ADD, 0), 1'b1, 1'b0);

        // lui, ori (zero-extended immediate)
        Inst_in = 32'h3C081234;
        step("lui_if", S_IF, IFV, 1'b1, 1'b0);
        step("lui_id", S_ID, IDV, 1'b1, 1'b0);
        step("lui_lui", S_LUI, LUIV, 1'b1, 1'b0);
        Inst_in = 32'h35080001;
        step("ori_if", S_IF, IFV, 1'b1, 1'b0);
        step("ori_id", S_ID, IDV, 1'b1, 1'b0);
        step("ori_exi", S_EXI, mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b10,2'b00, ALU_OR, 0), 1'b1, 1'b0);
        step("ori_wbi", S_WBI, mk(0,0,0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, ALU_ADD, 0), 1'b1, 1'b0);
        step("ori_back", S_IF, IFV, 1'b0, 1'b0);

        for (int i = 0; i < 10 && q_st.size() > 0; i++) @(posedge clk);
        if (q_st.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_st.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
